mux_sel_pipe: RTL and testbench

- Parametrised N-way operand select stage for the 16-bit datapath.
- Replaces the fixed-width combinational selects with a registered, flow-controlled version.
- Picks one of NUM_IN inputs by select code and registers the result behind a valid/ready handshake with a 2-entry skid buffer.
- Detects out-of-range select codes in hardware: per-transfer error tag, sticky flag and saturating error counter. Nothing is reported through simulation-only messages.

---
 rtl/mux_sel_pipe_if.sv | 27 ++
 rtl/mux_sel_pipe.sv | 204 ++++++++++++++++++++
 tb/tb_mux_sel_pipe.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mux_sel_pipe_if.sv
// Handshake bundle for the mux_sel_pipe operand-select stage.
// The upstream/downstream side (master) drives data, select and downstream ready.
// The stage (slave) drives upstream ready and the head-of-stage result.
interface mux_sel_pipe_if #(
  parameter int WIDTH  = 16,
  parameter int NUM_IN = 3,
  parameter int SEL_W  = 2
);
  logic [WIDTH*NUM_IN-1:0] I;
  logic [SEL_W-1:0]        S;
  logic                    IN_VALID;
  logic                    IN_READY;
  logic [WIDTH-1:0]        O;
  logic                    O_ERR;
  logic                    OUT_VALID;
  logic                    OUT_READY;

  modport master (
    output I, S, IN_VALID, OUT_READY,
    input  IN_READY, O, O_ERR, OUT_VALID
  );

  modport slave (
    input  I, S, IN_VALID, OUT_READY,
    output IN_READY, O, O_ERR, OUT_VALID
  );
endinterface

// File: rtl/mux_sel_pipe.sv
// Registered N-way operand select with valid/ready flow control.
// A 2-entry store (head + skid) keeps IN_READY a pure decode of registered
// state while still sustaining one transfer per cycle. Out-of-range select
// codes yield zero data tagged with an error bit, and are tallied in a
// sticky flag and a saturating counter.
module mux_sel_pipe #(
  parameter int WIDTH  = 16,
  parameter int NUM_IN = 3,
  parameter int SEL_W  = 2,
  parameter int CNT_W  = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  mux_sel_pipe_if.slave    bus,
  output logic             ERR_STICKY,
  output logic [CNT_W-1:0] ERR_CNT,
  input  logic             ERR_CLR
);

  localparam int               NUM_CODES  = 2 ** SEL_W;
  localparam logic [SEL_W:0]   LP_NUM_IN  = (SEL_W + 1)'(NUM_IN);
  localparam logic [CNT_W-1:0] LP_CNT_MAX = '1;
  localparam logic [CNT_W-1:0] LP_CNT_ONE = CNT_W'(1);

  // Occupancy of the head/skid pair.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic [WIDTH-1:0] r_head_data;
  logic             r_head_err;
  logic [WIDTH-1:0] r_skid_data;
  logic             r_skid_err;
  logic             r_err_sticky;
  logic [CNT_W-1:0] r_err_cnt;

  logic [WIDTH-1:0] w_slices [NUM_CODES];
  logic             w_in_range;
  logic [WIDTH-1:0] w_sel_data;
  logic             w_sel_err;
  logic             w_in_ready;
  logic             w_out_valid;
  logic             w_in_fire;
  logic             w_out_fire;
  logic             w_err_evt;
  logic             w_load_head_in;
  logic             w_load_head_skid;
  logic             w_load_skid;
  logic             w_clr_head;

  // Every possible select code gets a slot; codes past NUM_IN read as zero.
  for (genvar k = 0; k < NUM_CODES; k++) begin : g_slice
    if (k < NUM_IN) begin : g_real
      assign w_slices[k] = bus.I[k*WIDTH +: WIDTH];
    end else begin : g_pad
      assign w_slices[k] = '0;
    end
  end

  // Ready/valid are decodes of the registered occupancy only; the unused
  // encoding reports neither, so it cannot accept or emit anything.
  assign w_in_ready  = (r_state == ST_EMPTY) || (r_state == ST_ONE);
  assign w_out_valid = (r_state == ST_ONE)   || (r_state == ST_FULL);
  assign w_in_fire   = bus.IN_VALID && w_in_ready;
  assign w_out_fire  = w_out_valid && bus.OUT_READY;
  assign w_in_range  = ({1'b0, bus.S} < LP_NUM_IN);
  assign w_err_evt   = w_in_fire && w_sel_err;

  // Input-side select decode: in-range picks the slice, otherwise zero + error.
  always_comb begin
    w_sel_data = '0;
    w_sel_err  = 1'b0;
    if (w_in_range) begin
      w_sel_data = w_slices[bus.S];
      w_sel_err  = 1'b0;
    end else begin
      w_sel_data = '0;
      w_sel_err  = 1'b1;
    end
  end

  // Next occupancy plus the head/skid load strobes for this cycle.
  always_comb begin
    w_state_nxt      = r_state;
    w_load_head_in   = 1'b0;
    w_load_head_skid = 1'b0;
    w_load_skid      = 1'b0;
    w_clr_head       = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (w_in_fire) begin
          w_state_nxt    = ST_ONE;
          w_load_head_in = 1'b1;
        end else begin
          w_state_nxt    = ST_EMPTY;
        end
      end
      ST_ONE: begin
        if (w_in_fire && w_out_fire) begin
          w_state_nxt    = ST_ONE;
          w_load_head_in = 1'b1;
        end else if (w_in_fire) begin
          w_state_nxt    = ST_FULL;
          w_load_skid    = 1'b1;
        end else if (w_out_fire) begin
          w_state_nxt    = ST_EMPTY;
          w_clr_head     = 1'b1;
        end else begin
          w_state_nxt    = ST_ONE;
        end
      end
      ST_FULL: begin
        if (w_out_fire) begin
          w_state_nxt      = ST_ONE;
          w_load_head_skid = 1'b1;
        end else begin
          w_state_nxt      = ST_FULL;
        end
      end
      default: begin
        w_state_nxt = ST_EMPTY;
        w_clr_head  = 1'b1;
      end
    endcase
  end

  // Occupancy register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Head entry: loads from input or skid, and is zeroed when drained so O
  // never shows a stale value while OUT_VALID is low.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_head_data <= '0;
      r_head_err  <= 1'b0;
    end else if (w_load_head_in) begin
      r_head_data <= w_sel_data;
      r_head_err  <= w_sel_err;
    end else if (w_load_head_skid) begin
      r_head_data <= r_skid_data;
      r_head_err  <= r_skid_err;
    end else if (w_clr_head) begin
      r_head_data <= '0;
      r_head_err  <= 1'b0;
    end else begin
      r_head_data <= r_head_data;
      r_head_err  <= r_head_err;
    end
  end

  // Skid entry: catches the one input accepted while the head is stalled.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_skid_data <= '0;
      r_skid_err  <= 1'b0;
    end else if (w_load_skid) begin
      r_skid_data <= w_sel_data;
      r_skid_err  <= w_sel_err;
    end else begin
      r_skid_data <= r_skid_data;
      r_skid_err  <= r_skid_err;
    end
  end

  // Error statistics: clear wins over a same-cycle event; counter saturates.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_err_sticky <= 1'b0;
      r_err_cnt    <= '0;
    end else if (ERR_CLR) begin
      r_err_sticky <= 1'b0;
      r_err_cnt    <= '0;
    end else if (w_err_evt) begin
      r_err_sticky <= 1'b1;
      if (r_err_cnt != LP_CNT_MAX) begin
        r_err_cnt <= r_err_cnt + LP_CNT_ONE;
      end else begin
        r_err_cnt <= r_err_cnt;
      end
    end else begin
      r_err_sticky <= r_err_sticky;
      r_err_cnt    <= r_err_cnt;
    end
  end

  assign bus.IN_READY  = w_in_ready;
  assign bus.OUT_VALID = w_out_valid;
  assign bus.O         = r_head_data;
  assign bus.O_ERR     = r_head_err;
  assign ERR_STICKY    = r_err_sticky;
  assign ERR_CNT       = r_err_cnt;

endmodule

// File: tb/tb_mux_sel_pipe.sv
// Scoreboard bench for mux_sel_pipe: a 3-input/16-bit instance for the
// handshake, error and reset behaviour, and a 16-input/8-bit instance for
// full select coverage. Stimulus pushes expectations; monitors pop/compare.
module tb_mux_sel_pipe;

  logic clk;
  logic rst_n;
  logic err_clr_a;
  logic err_clr_b;
  logic       sticky_a;
  logic [7:0] cnt_a;
  logic       sticky_b;
  logic [7:0] cnt_b;

  int n_checks;
  int n_errors;
  int out_cnt_a;
  int out_cnt_b;

  logic [16:0] q_a [$];
  logic [8:0]  q_b [$];

  mux_sel_pipe_if #(.WIDTH(16), .NUM_IN(3),  .SEL_W(2)) bus_a ();
  mux_sel_pipe_if #(.WIDTH(8),  .NUM_IN(16), .SEL_W(4)) bus_b ();

  mux_sel_pipe #(.WIDTH(16), .NUM_IN(3), .SEL_W(2), .CNT_W(8)) dut_a (
    .CLK(clk), .RST_N(rst_n), .bus(bus_a),
    .ERR_STICKY(sticky_a), .ERR_CNT(cnt_a), .ERR_CLR(err_clr_a)
  );

  mux_sel_pipe #(.WIDTH(8), .NUM_IN(16), .SEL_W(4), .CNT_W(8)) dut_b (
    .CLK(clk), .RST_N(rst_n), .bus(bus_b),
    .ERR_STICKY(sticky_b), .ERR_CNT(cnt_b), .ERR_CLR(err_clr_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor A: every output transfer must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && bus_a.OUT_VALID && bus_a.OUT_READY) begin
      out_cnt_a++;
      if (q_a.size() == 0) begin
        check("a_unexpected_out", 32'(bus_a.O), 32'hFFFF_FFFF);
      end else begin
        logic [16:0] e;
        e = q_a.pop_front();
        check("a_out_data", 32'(bus_a.O), 32'(e[16:1]));
        check("a_out_err", 32'(bus_a.O_ERR), 32'(e[0]));
      end
    end
  end

  // Monitor B: same scheme for the 16-way instance.
  always @(negedge clk) begin
    if (rst_n && bus_b.OUT_VALID && bus_b.OUT_READY) begin
      out_cnt_b++;
      if (q_b.size() == 0) begin
        check("b_unexpected_out", 32'(bus_b.O), 32'hFFFF_FFFF);
      end else begin
        logic [8:0] e;
        e = q_b.pop_front();
        check("b_out_data", 32'(bus_b.O), 32'(e[8:1]));
        check("b_out_err", 32'(bus_b.O_ERR), 32'(e[0]));
      end
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send_a(input logic [15:0] i0, input logic [15:0] i1, input logic [15:0] i2,
                        input logic [1:0] s, input logic [15:0] ed, input logic ee);
    bit acc;
    acc = 1'b0;
    bus_a.I = {i2, i1, i0};
    bus_a.S = s;
    bus_a.IN_VALID = 1'b1;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (bus_a.IN_READY) begin
        q_a.push_back({ed, ee});
        acc = 1'b1;
      end
      @(posedge clk);
      #1;
      if (acc) break;
    end
    if (!acc) check("a_accept_timeout", 32'd0, 32'd1);
    bus_a.IN_VALID = 1'b0;
  endtask

  task automatic send_b(input logic [3:0] s, input logic [7:0] ed);
    bit acc;
    acc = 1'b0;
    bus_b.S = s;
    bus_b.IN_VALID = 1'b1;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (bus_b.IN_READY) begin
        q_b.push_back({ed, 1'b0});
        acc = 1'b1;
      end
      @(posedge clk);
      #1;
      if (acc) break;
    end
    if (!acc) check("b_accept_timeout", 32'd0, 32'd1);
    bus_b.IN_VALID = 1'b0;
  endtask

  // Global time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    n_checks = 0; n_errors = 0; out_cnt_a = 0; out_cnt_b = 0;
    rst_n = 1'b0; err_clr_a = 1'b0; err_clr_b = 1'b0;
    bus_a.I = '0; bus_a.S = '0; bus_a.IN_VALID = 1'b0; bus_a.OUT_READY = 1'b0;
    bus_b.I = '0; bus_b.S = '0; bus_b.IN_VALID = 1'b0; bus_b.OUT_READY = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(bus_a.OUT_VALID), 32'd0);
    check("rst_in_ready", 32'(bus_a.IN_READY), 32'd1);
    check("rst_o", 32'(bus_a.O), 32'h0000);
    check("rst_o_err", 32'(bus_a.O_ERR), 32'd0);
    check("rst_sticky", 32'(sticky_a), 32'd0);
    check("rst_cnt", 32'(cnt_a), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Back-to-back in-range selects with downstream always ready.
    bus_a.OUT_READY = 1'b1;
    c0 = out_cnt_a;
    send_a(16'h1111, 16'h2222, 16'h3333, 2'd0, 16'h1111, 1'b0);
    send_a(16'h1111, 16'h2222, 16'h3333, 2'd1, 16'h2222, 1'b0);
    send_a(16'h1111, 16'h2222, 16'h3333, 2'd2, 16'h3333, 1'b0);
    @(negedge clk);
    #1;
    check("no_bubbles", 32'(out_cnt_a - c0), 32'd3);
    @(posedge clk);
    #1;
    check("drained_valid", 32'(bus_a.OUT_VALID), 32'd0);

    // Out-of-range select.
    send_a(16'hDEAD, 16'hBEEF, 16'hCAFE, 2'd3, 16'h0000, 1'b1);
    check("err_sticky_1", 32'(sticky_a), 32'd1);
    check("err_cnt_1", 32'(cnt_a), 32'd1);
    @(posedge clk);
    #1;

    // Stall: A then B with downstream blocked.
    bus_a.OUT_READY = 1'b0;
    send_a(16'hAAAA, 16'h0000, 16'h0000, 2'd0, 16'hAAAA, 1'b0);
    check("one_in_ready", 32'(bus_a.IN_READY), 32'd1);
    send_a(16'h0000, 16'hBBBB, 16'h0000, 2'd1, 16'hBBBB, 1'b0);
    check("full_in_ready", 32'(bus_a.IN_READY), 32'd0);
    check("full_hold_o", 32'(bus_a.O), 32'hAAAA);
    repeat (2) @(posedge clk);
    #1;
    check("full_hold_o_later", 32'(bus_a.O), 32'hAAAA);
    check("full_hold_valid", 32'(bus_a.OUT_VALID), 32'd1);
    bus_a.OUT_READY = 1'b1;
    @(posedge clk);
    #1;
    check("after_drain_in_ready", 32'(bus_a.IN_READY), 32'd1);
    check("after_drain_o", 32'(bus_a.O), 32'hBBBB);
    @(posedge clk);
    #1;
    check("stall_empty", 32'(bus_a.OUT_VALID), 32'd0);

    // Saturation: 260 more errors on top of the one already counted.
    for (int i = 0; i < 260; i++) begin
      send_a(16'h1234, 16'h5678, 16'h9ABC, 2'd3, 16'h0000, 1'b1);
      if (i == 253) check("cnt_reach_max", 32'(cnt_a), 32'd255);
    end
    check("cnt_saturated", 32'(cnt_a), 32'd255);
    check("sticky_saturated", 32'(sticky_a), 32'd1);
    err_clr_a = 1'b1;
    send_a(16'h1234, 16'h5678, 16'h9ABC, 2'd3, 16'h0000, 1'b1);
    err_clr_a = 1'b0;
    check("clr_prio_cnt", 32'(cnt_a), 32'd0);
    check("clr_prio_sticky", 32'(sticky_a), 32'd0);
    send_a(16'h1234, 16'h5678, 16'h9ABC, 2'd3, 16'h0000, 1'b1);
    check("count_after_clr", 32'(cnt_a), 32'd1);

    // Out-of-range select that is never accepted.
    bus_a.S = 2'd3;
    repeat (3) @(posedge clk);
    #1;
    check("unaccepted_no_count", 32'(cnt_a), 32'd1);

    // Asynchronous reset while FULL.
    bus_a.OUT_READY = 1'b0;
    send_a(16'h5A5A, 16'h0000, 16'h0000, 2'd0, 16'h5A5A, 1'b0);
    send_a(16'h0000, 16'hA5A5, 16'h0000, 2'd1, 16'hA5A5, 1'b0);
    check("pre_rst_full", 32'(bus_a.IN_READY), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(bus_a.OUT_VALID), 32'd0);
    check("async_rst_ready", 32'(bus_a.IN_READY), 32'd1);
    check("async_rst_o", 32'(bus_a.O), 32'h0000);
    check("async_rst_cnt", 32'(cnt_a), 32'd0);
    q_a.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    bus_a.OUT_READY = 1'b1;
    c0 = out_cnt_a;
    send_a(16'h0000, 16'h0000, 16'hC3C3, 2'd2, 16'hC3C3, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("post_rst_single_out", 32'(out_cnt_a - c0), 32'd1);
    check("post_rst_queue_empty", 32'(q_a.size()), 32'd0);

    // 16-way instance: every code selects its own slice.
    bus_b.OUT_READY = 1'b1;
    for (int k = 0; k < 16; k++) bus_b.I[k*8 +: 8] = 8'(k * 17);
    for (int k = 0; k < 16; k++) send_b(4'(k), 8'(k * 17));
    repeat (2) @(posedge clk);
    #1;
    check("b_all_outputs", 32'(out_cnt_b), 32'd16);
    check("b_no_sticky", 32'(sticky_b), 32'd0);
    check("b_no_cnt", 32'(cnt_b), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
